risc_ctrl_fsm: RTL and testbench

- Instruction sequencer for the 8-bit RISC CPU.
- Runs a fixed 8-cycle fetch/decode/execute sequence per instruction and drives the PC, IR, accumulator, memory and ALU control strobes.
- Sits beside the ALU and consumes its 3-bit opcode encoding and its zero flag.
- Also owns the HALT state.

---
 rtl/risc_ctrl_fsm.sv | 178 +++++++++++++++++
 tb/tb_risc_ctrl_fsm.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/risc_ctrl_fsm.sv
// rtl/risc_ctrl_fsm.sv - 8-phase fetch/decode/execute sequencer for the 8-bit RISC CPU
//
// Purpose: steps every instruction through eight phases S0..S7 and issues the
// PC, IR, accumulator, memory and ALU control strobes for each phase. It also
// owns the HALTED state, which is entered from S3 of a HALT instruction and
// left by resume.
//
// Ports:
//   clk         system clock, rising edge
//   rst         synchronous active-high reset
//   opcode      IR[15:13]: HALT=000 JRZ=001 ADD=010 AND=011 XOR=100
//               LOAD=101 STORE=110 JUMP=111
//   zero        ALU zero flag
//   resume      leave HALTED (level-sampled)
//   inc_pc      increment program counter
//   load_pc     load PC from the IR address field
//   load_ir     latch data_bus into IR (S0 high byte, S1 low byte)
//   load_acc    latch ALU output into accumulator
//   alu_ena     ALU evaluates opcode this cycle
//   rd          memory read enable
//   wr          memory write enable
//   datactl_ena drive accumulator onto data_bus
//   halted      CPU is in HALTED state
//   phase       current phase S0..S7

module risc_ctrl_fsm (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] opcode,
  input  logic       zero,
  input  logic       resume,
  output logic       inc_pc,
  output logic       load_pc,
  output logic       load_ir,
  output logic       load_acc,
  output logic       alu_ena,
  output logic       rd,
  output logic       wr,
  output logic       datactl_ena,
  output logic       halted,
  output logic [2:0] phase
);

  localparam int CYC_W = 3;

  localparam logic [2:0] OP_HALT  = 3'b000;
  localparam logic [2:0] OP_JRZ   = 3'b001;
  localparam logic [2:0] OP_ADD   = 3'b010;
  localparam logic [2:0] OP_AND   = 3'b011;
  localparam logic [2:0] OP_XOR   = 3'b100;
  localparam logic [2:0] OP_LOAD  = 3'b101;
  localparam logic [2:0] OP_STORE = 3'b110;
  localparam logic [2:0] OP_JUMP  = 3'b111;

  localparam logic [CYC_W-1:0] S0 = 3'd0;
  localparam logic [CYC_W-1:0] S1 = 3'd1;
  localparam logic [CYC_W-1:0] S3 = 3'd3;
  localparam logic [CYC_W-1:0] S4 = 3'd4;
  localparam logic [CYC_W-1:0] S5 = 3'd5;
  localparam logic [CYC_W-1:0] S6 = 3'd6;
  localparam logic [CYC_W-1:0] S7 = 3'd7;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } state_t;

  typedef struct packed {
    logic inc_pc;
    logic load_pc;
    logic load_ir;
    logic load_acc;
    logic alu_ena;
    logic rd;
    logic wr;
    logic datactl_ena;
  } strobes_t;

  state_t           state;
  state_t           nxt_state;
  logic [CYC_W-1:0] nxt_phase;
  strobes_t         nxt_strobes;

  // Strobes that belong to a given (state, phase). Outputs are registered, so
  // this is evaluated for the phase being entered, using opcode/zero as seen
  // at that edge; the strobes then line up with the phase they describe.
  function automatic strobes_t decode(input state_t st, input logic [CYC_W-1:0] ph,
                                      input logic [2:0] op, input logic z);
    strobes_t s;
    s = '0;
    if (st == ST_RUN) begin
      if (ph == S0 || ph == S1) begin
        s.rd      = 1'b1;
        s.load_ir = 1'b1;
        s.inc_pc  = 1'b1;
      end else begin
        case (op)
          OP_ADD, OP_AND, OP_XOR, OP_LOAD: begin
            if (ph == S4) begin
              s.alu_ena = 1'b1;
              s.rd      = 1'b1;
            end
            if (ph == S5) begin
              s.rd       = 1'b1;
              s.load_acc = 1'b1;
            end
          end
          OP_STORE: begin
            if (ph == S4) s.alu_ena = 1'b1;
            // Bus is driven one cycle either side of the write pulse.
            if (ph == S4 || ph == S5 || ph == S6) s.datactl_ena = 1'b1;
            if (ph == S5) s.wr = 1'b1;
          end
          OP_JUMP: begin
            if (ph == S4) s.alu_ena = 1'b1;
            if (ph == S4 || ph == S5) s.load_pc = 1'b1;
          end
          OP_JRZ: begin
            if (ph == S4) s.alu_ena = 1'b1;
            // Two conditional increments skip the following 16-bit word.
            if (ph == S5 || ph == S7) s.inc_pc = z;
          end
          default: begin
            // HALT and anything unrecognised: fetch strobes only.
          end
        endcase
      end
    end
    return s;
  endfunction

  always_comb begin
    nxt_state = state;
    nxt_phase = phase;
    if (state == ST_HALTED) begin
      if (resume) begin
        nxt_state = ST_RUN;
        nxt_phase = S0;
      end
    end else if (phase == S3 && opcode == OP_HALT) begin
      // Phase parks at S4 while halted; PC already points past HALT.
      nxt_state = ST_HALTED;
      nxt_phase = S4;
    end else begin
      nxt_phase = phase + 3'd1;
    end
    nxt_strobes = decode(nxt_state, nxt_phase, opcode, zero);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_RUN;
      phase       <= S0;
      halted      <= 1'b0;
      inc_pc      <= 1'b0;
      load_pc     <= 1'b0;
      load_ir     <= 1'b0;
      load_acc    <= 1'b0;
      alu_ena     <= 1'b0;
      rd          <= 1'b0;
      wr          <= 1'b0;
      datactl_ena <= 1'b0;
    end else begin
      state       <= nxt_state;
      phase       <= nxt_phase;
      halted      <= (nxt_state == ST_HALTED);
      inc_pc      <= nxt_strobes.inc_pc;
      load_pc     <= nxt_strobes.load_pc;
      load_ir     <= nxt_strobes.load_ir;
      load_acc    <= nxt_strobes.load_acc;
      alu_ena     <= nxt_strobes.alu_ena;
      rd          <= nxt_strobes.rd;
      wr          <= nxt_strobes.wr;
      datactl_ena <= nxt_strobes.datactl_ena;
    end
  end

endmodule

// File: tb/tb_risc_ctrl_fsm.sv
// tb/tb_risc_ctrl_fsm.sv - scoreboard bench for risc_ctrl_fsm

module tb_risc_ctrl_fsm;

  localparam logic [2:0] HALT  = 3'b000;
  localparam logic [2:0] JRZ   = 3'b001;
  localparam logic [2:0] ADD   = 3'b010;
  localparam logic [2:0] ANDI  = 3'b011;
  localparam logic [2:0] XORI  = 3'b100;
  localparam logic [2:0] LOAD  = 3'b101;
  localparam logic [2:0] STORE = 3'b110;
  localparam logic [2:0] JUMP  = 3'b111;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] opcode = 3'b010;
  logic       zero = 1'b0;
  logic       resume = 1'b0;
  logic       inc_pc, load_pc, load_ir, load_acc, alu_ena, rd, wr, datactl_ena, halted;
  logic [2:0] phase;

  int checks = 0;
  int errors = 0;
  int inc_cnt = 0;

  // Expected {halted, phase, inc_pc, load_pc, load_ir, load_acc, alu_ena, rd, wr, datactl_ena}
  logic [11:0] sb_q[$];
  logic [2:0]  m_phase;
  logic        m_halted;

  risc_ctrl_fsm dut (
    .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .resume(resume),
    .inc_pc(inc_pc), .load_pc(load_pc), .load_ir(load_ir), .load_acc(load_acc),
    .alu_ena(alu_ena), .rd(rd), .wr(wr), .datactl_ena(datactl_ena),
    .halted(halted), .phase(phase)
  );

  always #5 clk = ~clk;

  // Strobe table in the running state, order as in the scoreboard word.
  function automatic logic [7:0] model(input logic [2:0] p, input logic [2:0] op, input logic z);
    logic is_alu;
    is_alu = (op === ADD) || (op === ANDI) || (op === XORI) || (op === LOAD);
    if (p < 3'd2) return 8'b1010_0100;
    case (p)
      3'd4: begin
        if (is_alu)       return 8'b0000_1100;
        if (op === STORE) return 8'b0000_1001;
        if (op === JUMP)  return 8'b0100_1000;
        if (op === JRZ)   return 8'b0000_1000;
        return 8'b0;
      end
      3'd5: begin
        if (is_alu)       return 8'b0001_0100;
        if (op === STORE) return 8'b0000_0011;
        if (op === JUMP)  return 8'b0100_0000;
        if (op === JRZ)   return {z, 7'b0};
        return 8'b0;
      end
      3'd6: return (op === STORE) ? 8'b0000_0001 : 8'b0;
      3'd7: return (op === JRZ) ? {z, 7'b0} : 8'b0;
      default: return 8'b0;
    endcase
  endfunction

  task automatic step(input logic r, input logic [2:0] op, input logic z,
                      input logic res, input string tag);
    logic [7:0]  s;
    logic [11:0] e;
    logic [11:0] o;
    @(negedge clk);
    rst = r; opcode = op; zero = z; resume = res;
    if (r) begin
      m_phase = 3'd0; m_halted = 1'b0; s = 8'b0;
    end else if (m_halted) begin
      if (res) begin
        m_halted = 1'b0; m_phase = 3'd0; s = model(3'd0, op, z);
      end else begin
        s = 8'b0;
      end
    end else if (m_phase == 3'd3 && op == HALT) begin
      m_halted = 1'b1; m_phase = 3'd4; s = 8'b0;
    end else begin
      m_phase = m_phase + 3'd1;
      s = model(m_phase, op, z);
    end
    sb_q.push_back({m_halted, m_phase, s});
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    o = {halted, phase, inc_pc, load_pc, load_ir, load_acc, alu_ena, rd, wr, datactl_ena};
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s obs=%b required=%b", tag, o, e);
    end
    if (inc_pc) inc_cnt++;
  endtask

  task automatic check_count(input int obs, input int req, input string tag);
    checks++;
    assert (obs === req) else begin
      errors++;
      $error("FAIL %s obs=%0d required=%0d", tag, obs, req);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout obs=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    step(1, ADD, 0, 0, "reset");
    step(1, ADD, 0, 1, "reset_resume");
    repeat (16) step(0, ADD, 0, 0, "add");
    check_count(int'(phase), 0, "add_8cyc_wrap");
    repeat (8) step(0, STORE, 0, 0, "store");
    inc_cnt = 0;
    repeat (8) step(0, JRZ, 1, 0, "jrz_z1");
    check_count(inc_cnt, 4, "jrz_z1_incs");
    inc_cnt = 0;
    repeat (8) step(0, JRZ, 0, 0, "jrz_z0");
    check_count(inc_cnt, 2, "jrz_z0_incs");
    repeat (8) step(0, JUMP, 0, 0, "jump");
    repeat (8) step(0, ANDI, 1'($urandom_range(0, 1)), 0, "and");
    repeat (8) step(0, XORI, 1'($urandom_range(0, 1)), 0, "xor");
    repeat (8) step(0, LOAD, 1'($urandom_range(0, 1)), 0, "load");
    repeat (8) step(0, ADD, 0, 1, "resume_in_run");
    repeat (4) step(0, HALT, 0, 0, "halt_enter");
    repeat (20) step(0, HALT, 0, 0, "halt_hold");
    step(0, HALT, 0, 1, "halt_resume");
    repeat (8) step(0, ADD, 0, 0, "after_resume");
    repeat (4) step(0, HALT, 0, 0, "halt_enter2");
    step(1, HALT, 0, 1, "rst_vs_resume");
    repeat (5) step(0, STORE, 0, 0, "store_to_s5");
    step(1, STORE, 0, 0, "rst_in_store");
    repeat (8) step(0, ADD, 0, 0, "add_tail");
    check_count(sb_q.size(), 0, "sb_empty");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
